// File: rtl/jt7759_pkg.sv
// Shared tables, FSM encoding and saturation helper for the multi-channel uPD7759 ADPCM decoder.
// Optional input gain is enabled with the JT7759_MCH_GAIN_EN macro.
package jt7759_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_MIX} fsm_e;

  // Signal step indexed by [state][nibble]; nibbles 8..15 mirror 0..7 with negated sign.
  localparam int STEP [16][16] = '{
    '{0,  0,  1,  2,  3,   5,   7,  10,  0,   0,  -1,  -2,  -3,   -5,   -7,  -10},
    '{0,  1,  2,  3,  4,   6,   8,  13,  0,  -1,  -2,  -3,  -4,   -6,   -8,  -13},
    '{0,  1,  2,  4,  5,   7,  10,  15,  0,  -1,  -2,  -4,  -5,   -7,  -10,  -15},
    '{0,  1,  3,  4,  6,   9,  13,  19,  0,  -1,  -3,  -4,  -6,   -9,  -13,  -19},
    '{0,  2,  3,  5,  8,  11,  15,  23,  0,  -2,  -3,  -5,  -8,  -11,  -15,  -23},
    '{0,  2,  4,  7, 10,  14,  19,  29,  0,  -2,  -4,  -7, -10,  -14,  -19,  -29},
    '{0,  3,  5,  8, 12,  16,  22,  33,  0,  -3,  -5,  -8, -12,  -16,  -22,  -33},
    '{1,  4,  7, 10, 15,  20,  29,  43, -1,  -4,  -7, -10, -15,  -20,  -29,  -43},
    '{1,  4,  8, 13, 18,  25,  35,  53, -1,  -4,  -8, -13, -18,  -25,  -35,  -53},
    '{1,  6, 10, 16, 22,  31,  43,  64, -1,  -6, -10, -16, -22,  -31,  -43,  -64},
    '{2,  7, 12, 19, 27,  37,  51,  76, -2,  -7, -12, -19, -27,  -37,  -51,  -76},
    '{2,  9, 16, 24, 34,  46,  64,  96, -2,  -9, -16, -24, -34,  -46,  -64,  -96},
    '{3, 11, 19, 29, 41,  57,  79, 117, -3, -11, -19, -29, -41,  -57,  -79, -117},
    '{4, 13, 24, 36, 50,  69,  96, 143, -4, -13, -24, -36, -50,  -69,  -96, -143},
    '{4, 16, 29, 44, 62,  85, 118, 175, -4, -16, -29, -44, -62,  -85, -118, -175},
    '{6, 20, 36, 54, 76, 104, 144, 214, -6, -20, -36, -54, -76, -104, -144, -214}
  };

  localparam int DELTA [16] = '{-1, -1, 0, 0, 1, 2, 2, 3, -1, -1, 0, 0, 1, 2, 2, 3};

  // Clamp v into the signed range of a w-bit word (w <= 31).
  function automatic int sat(input int v, input int w);
    int hi;
    hi = (1 << (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

endpackage

// File: rtl/jt7759_mch_if.sv
// Nibble-source / mixed-output bundle for jt7759_mch; the gain bus exists only with JT7759_MCH_GAIN_EN.
interface jt7759_mch_if #(
  parameter int CH = 4,
  parameter int SW = 14,
  parameter int MW = 16
);
  logic                 cendec;
  logic [CH-1:0]        ch_en;
  logic [CH-1:0]        ch_clr;
  logic [4*CH-1:0]      nib;
  logic [CH-1:0]        nib_valid;
  logic [CH-1:0]        nib_ready;
  logic [SW*CH-1:0]     ch_snd;
  logic signed [MW-1:0] mix;
  logic                 mix_valid;
  logic                 busy;
  logic [CH-1:0]        underrun;
  logic                 dropped;
`ifdef JT7759_MCH_GAIN_EN
  logic [4*CH-1:0]      gain;

  modport master (output cendec, ch_en, ch_clr, nib, nib_valid, gain,
                  input  nib_ready, ch_snd, mix, mix_valid, busy, underrun, dropped);
  modport slave  (input  cendec, ch_en, ch_clr, nib, nib_valid, gain,
                  output nib_ready, ch_snd, mix, mix_valid, busy, underrun, dropped);
`else
  modport master (output cendec, ch_en, ch_clr, nib, nib_valid,
                  input  nib_ready, ch_snd, mix, mix_valid, busy, underrun, dropped);
  modport slave  (input  cendec, ch_en, ch_clr, nib, nib_valid,
                  output nib_ready, ch_snd, mix, mix_valid, busy, underrun, dropped);
`endif
endinterface

// File: rtl/jt7759_mch_step.sv
// Single-channel ADPCM predictor update, shared by all slots of the sequencer.
module jt7759_mch_step
  import jt7759_pkg::*;
(
  input  logic signed [8:0] sig,
  input  logic [3:0]        st,
  input  logic [3:0]        n,
  output logic signed [8:0] sig_nxt,
  output logic [3:0]        st_nxt
);
  int sig_sum;
  int st_sum;

  always_comb begin
    sig_sum = int'(sig) + STEP[st][n];
    st_sum  = int'(st) + DELTA[n];
    sig_nxt = 9'(sat(sig_sum, 9));
    st_nxt  = 4'((st_sum < 0) ? 0 : ((st_sum > 15) ? 15 : st_sum));
  end
endmodule

// File: rtl/jt7759_mch.sv
// Time-multiplexed CH-voice uPD7759 ADPCM decoder with saturated mixer, one slot per clk.
// JT7759_MCH_GAIN_EN adds a per-channel 4-bit gain (8 = unity) and one extra pipeline cycle.
module jt7759_mch
  import jt7759_pkg::*;
#(
  parameter int CH = 4,
  parameter int SW = 14,
  parameter int MW = 16
)(
  input logic         clk,
  input logic         rstn,
  jt7759_mch_if.slave bus
);
  localparam int AW = SW + $clog2(CH) + 1;
  localparam int IW = $clog2(CH + 1);
`ifdef JT7759_MCH_GAIN_EN
  localparam int LAST = CH;      // final slot only drains the gain register
`else
  localparam int LAST = CH - 1;
`endif

  fsm_e                 fsm_reg;
  logic [IW-1:0]        idx_reg;
  logic signed [AW-1:0] acc_reg, acc_next, contrib, add_term;
  logic signed [8:0]    sig_reg [CH];
  logic [3:0]           st_reg [CH];
  logic signed [MW-1:0] mix_reg;
  logic                 mix_valid_reg, busy_reg, dropped_reg;
  logic [CH-1:0]        underrun_reg, slot_hit, ready, und_evt;

  logic                 cur_en, cur_clr, cur_vld, decode, starve;
  logic [3:0]           cur_nib, cur_st, step_st;
  logic signed [8:0]    cur_sig, step_sig, slot_sig;
  logic signed [SW-1:0] slot_sample;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    assign slot_hit[gi] = (fsm_reg == ST_RUN) && (idx_reg == IW'(gi));
    assign bus.ch_snd[SW*gi +: SW] = SW'(sig_reg[gi]) <<< (SW - 9);
  end

`ifdef JT7759_MCH_GAIN_EN
  logic [3:0]           cur_gain;
  logic signed [SW+4:0] prod;
  logic signed [AW-1:0] contrib_reg;
`endif

  always_comb begin
    cur_en  = 1'b0;
    cur_clr = 1'b0;
    cur_vld = 1'b0;
    cur_nib = '0;
    cur_sig = '0;
    cur_st  = '0;
`ifdef JT7759_MCH_GAIN_EN
    cur_gain = '0;
`endif
    for (int i = 0; i < CH; i++) begin
      if (slot_hit[i]) begin
        cur_en  = bus.ch_en[i];
        cur_clr = bus.ch_clr[i];
        cur_vld = bus.nib_valid[i];
        cur_nib = bus.nib[4*i +: 4];
        cur_sig = sig_reg[i];
        cur_st  = st_reg[i];
`ifdef JT7759_MCH_GAIN_EN
        cur_gain = bus.gain[4*i +: 4];
`endif
      end
    end
  end

  jt7759_mch_step u_step (
    .sig     (cur_sig),
    .st      (cur_st),
    .n       (cur_nib),
    .sig_nxt (step_sig),
    .st_nxt  (step_st)
  );

  // A clear wins over decode; a starved channel still contributes its held sample.
  assign decode      = cur_en & ~cur_clr & cur_vld;
  assign starve      = cur_en & ~cur_clr & ~cur_vld;
  assign ready       = decode ? slot_hit : '0;
  assign und_evt     = starve ? slot_hit : '0;
  assign slot_sig    = cur_clr ? 9'sd0 : (decode ? step_sig : cur_sig);
  assign slot_sample = SW'(slot_sig) <<< (SW - 9);

`ifdef JT7759_MCH_GAIN_EN
  assign prod     = (SW+5)'(slot_sample) * (SW+5)'($signed({1'b0, cur_gain}));
  assign contrib  = cur_en ? AW'(prod >>> 3) : '0;
  assign add_term = contrib_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) contrib_reg <= '0;
    else       contrib_reg <= contrib;
  end
`else
  assign contrib  = cur_en ? AW'(slot_sample) : '0;
  assign add_term = contrib;
`endif

  assign acc_next = acc_reg + add_term;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CH; i++) begin
        sig_reg[i] <= '0;
        st_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (bus.ch_clr[i]) begin
          sig_reg[i] <= '0;
          st_reg[i]  <= '0;
        end else if (ready[i]) begin
          sig_reg[i] <= step_sig;
          st_reg[i]  <= step_st;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_reg       <= ST_IDLE;
      idx_reg       <= '0;
      acc_reg       <= '0;
      mix_reg       <= '0;
      mix_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      dropped_reg   <= 1'b0;
      underrun_reg  <= '0;
    end else begin
      mix_valid_reg <= 1'b0;
      underrun_reg  <= underrun_reg | und_evt;
      if (bus.cendec && busy_reg) dropped_reg <= 1'b1;
      case (fsm_reg)
        ST_IDLE: if (bus.cendec) begin
          fsm_reg  <= ST_RUN;
          idx_reg  <= '0;
          acc_reg  <= '0;
          busy_reg <= 1'b1;
        end
        ST_RUN: begin
          acc_reg <= acc_next;
          idx_reg <= idx_reg + 1'b1;
          if (idx_reg == IW'(LAST)) begin
            fsm_reg       <= ST_MIX;
            mix_reg       <= MW'(sat(int'(acc_next), MW));
            mix_valid_reg <= 1'b1;
          end
        end
        ST_MIX: begin
          fsm_reg  <= ST_IDLE;
          busy_reg <= 1'b0;
        end
        default: fsm_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.nib_ready = ready;
  assign bus.mix       = mix_reg;
  assign bus.mix_valid = mix_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.underrun  = underrun_reg;
  assign bus.dropped   = dropped_reg;
endmodule

// File: tb/tb_jt7759_mch.sv
// Directed bench for jt7759_mch: a reference ADPCM model queues expected mixes, checked at mix_valid.
`timescale 1ns/1ps
module tb_jt7759_mch;
  localparam int CH = 4, SW = 14, MW = 16;
`ifdef JT7759_MCH_GAIN_EN
  localparam int LAT = CH + 2;
`else
  localparam int LAT = CH + 1;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  jt7759_mch_if #(.CH(CH), .SW(SW), .MW(MW)) bus ();
  jt7759_mch_if #(.CH(CH), .SW(SW), .MW(14)) bus14 ();

  assign bus14.cendec    = bus.cendec;
  assign bus14.ch_en     = bus.ch_en;
  assign bus14.ch_clr    = bus.ch_clr;
  assign bus14.nib       = bus.nib;
  assign bus14.nib_valid = bus.nib_valid;
`ifdef JT7759_MCH_GAIN_EN
  assign bus14.gain      = bus.gain;
`endif

  jt7759_mch #(.CH(CH), .SW(SW), .MW(MW)) dut   (.clk(clk), .rstn(rstn), .bus(bus));
  jt7759_mch #(.CH(CH), .SW(SW), .MW(14)) dut14 (.clk(clk), .rstn(rstn), .bus(bus14));

  // Positive half of the step table; negative nibbles use the negated magnitude.
  int mag [16][8] = '{
    '{0, 0, 1, 2, 3, 5, 7, 10},     '{0, 1, 2, 3, 4, 6, 8, 13},
    '{0, 1, 2, 4, 5, 7, 10, 15},    '{0, 1, 3, 4, 6, 9, 13, 19},
    '{0, 2, 3, 5, 8, 11, 15, 23},   '{0, 2, 4, 7, 10, 14, 19, 29},
    '{0, 3, 5, 8, 12, 16, 22, 33},  '{1, 4, 7, 10, 15, 20, 29, 43},
    '{1, 4, 8, 13, 18, 25, 35, 53}, '{1, 6, 10, 16, 22, 31, 43, 64},
    '{2, 7, 12, 19, 27, 37, 51, 76}, '{2, 9, 16, 24, 34, 46, 64, 96},
    '{3, 11, 19, 29, 41, 57, 79, 117}, '{4, 13, 24, 36, 50, 69, 96, 143},
    '{4, 16, 29, 44, 62, 85, 118, 175}, '{6, 20, 36, 54, 76, 104, 144, 214}
  };
  int dst [8] = '{-1, -1, 0, 0, 1, 2, 2, 3};

  typedef struct packed {
    logic signed [31:0]   mix;
    logic signed [31:0]   mix14;
    logic [CH-1:0][31:0]  snd;
    logic [CH-1:0]        rdy;
    logic [CH-1:0]        und;
  } exp_t;

  exp_t          exp_q [$];
  int            m_sig [CH];
  int            m_st  [CH];
  int            m_gain [CH];
  logic [CH-1:0] m_und;
  logic          m_drop;
  int            errors = 0;
  int            checks = 0;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int snd_of(input int i);
    return int'($signed(bus.ch_snd[SW*i +: SW]));
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame(input string tag, input logic [CH-1:0] en, input logic [CH-1:0] clr,
                       input logic [CH-1:0] vld, input logic [4*CH-1:0] nibs, input bit extra);
    exp_t e;
    int   sum, cyc, extra_mv, n, d, samp;
    e = '0;
    sum = 0;
    for (int i = 0; i < CH; i++) begin
      n = int'(nibs[4*i +: 4]);
      if (clr[i]) begin
        m_sig[i] = 0;
        m_st[i]  = 0;
      end else if (en[i] && vld[i]) begin
        d = mag[m_st[i]][n % 8];
        if (n >= 8) d = -d;
        m_sig[i] = clamp(m_sig[i] + d, -256, 255);
        m_st[i]  = clamp(m_st[i] + dst[n % 8], 0, 15);
        e.rdy[i] = 1'b1;
      end else if (en[i]) begin
        m_und[i] = 1'b1;
      end
      samp = m_sig[i] * 32;
      e.snd[i] = samp;
      if (en[i]) sum += (samp * m_gain[i]) >>> 3;
    end
    e.mix   = clamp(sum, -32768, 32767);
    e.mix14 = clamp(sum, -8192, 8191);
    e.und   = m_und;
    if (extra) m_drop = 1'b1;
    exp_q.push_back(e);

    @(negedge clk);
    bus.ch_en = en; bus.ch_clr = clr; bus.nib_valid = vld; bus.nib = nibs; bus.cendec = 1'b1;
    @(negedge clk);
    bus.cendec = 1'b0;
    cyc = 1;
    while (bus.mix_valid !== 1'b1 && cyc <= LAT + 4) begin
      check($sformatf("%s nib_ready c%0d", tag, cyc), int'(bus.nib_ready),
            (cyc <= CH) ? int'(e.rdy & (1 << (cyc - 1))) : 0);
      if (cyc == 1) check({tag, " busy"}, int'(bus.busy), 1);
      bus.cendec = (extra && cyc == 1);
      @(negedge clk);
      cyc++;
    end
    bus.cendec = 1'b0;
    check({tag, " latency"}, cyc, LAT);
    e = exp_q.pop_front();
    check({tag, " mix"}, int'(bus.mix), e.mix);
    check({tag, " mix14"}, int'(bus14.mix), e.mix14);
    for (int i = 0; i < CH; i++) check($sformatf("%s ch_snd%0d", tag, i), snd_of(i), int'(e.snd[i]));
    check({tag, " underrun"}, int'(bus.underrun), int'(e.und));
    bus.ch_clr = '0;
    extra_mv = 0;
    repeat (CH + 3) begin
      @(negedge clk);
      if (bus.mix_valid) extra_mv++;
    end
    check({tag, " single mix_valid"}, extra_mv, 0);
    check({tag, " idle busy"}, int'(bus.busy), 0);
    check({tag, " dropped"}, int'(bus.dropped), int'(m_drop));
    $display("frame %-10s en=%b nib=%h mix=%0d mix14=%0d", tag, en, nibs, int'(bus.mix), int'(bus14.mix));
  endtask

  initial begin
    bus.cendec = 1'b0; bus.ch_en = '0; bus.ch_clr = '0; bus.nib = '0; bus.nib_valid = '0;
`ifdef JT7759_MCH_GAIN_EN
    bus.gain = {CH{4'd8}};
`endif
    for (int i = 0; i < CH; i++) begin m_sig[i] = 0; m_st[i] = 0; m_gain[i] = 8; end
    m_und = '0;
    m_drop = 1'b0;

    repeat (3) @(negedge clk);
    check("reset mix", int'(bus.mix), 0);
    check("reset mix_valid", int'(bus.mix_valid), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset underrun", int'(bus.underrun), 0);
    check("reset dropped", int'(bus.dropped), 0);
    check("reset nib_ready", int'(bus.nib_ready), 0);
    for (int i = 0; i < CH; i++) check($sformatf("reset ch_snd%0d", i), snd_of(i), 0);
    rstn = 1'b1;

    frame("first", 4'b0001, 4'b0000, 4'b1111, 16'h0004, 1'b0);
    check("first ch_snd0 const", snd_of(0), 96);
    frame("negative", 4'b0010, 4'b0000, 4'b1111, 16'h00C0, 1'b0);
    check("negative ch_snd1 const", snd_of(1), -96);
    frame("underrun", 4'b0011, 4'b0000, 4'b0001, 16'h0000, 1'b0);
    check("underrun flag const", int'(bus.underrun), 2);
    frame("ch2_load", 4'b0100, 4'b0000, 4'b1111, 16'h0700, 1'b0);
    frame("ch2_clr", 4'b0100, 4'b0100, 4'b1111, 16'h0700, 1'b0);
    frame("ch2_after", 4'b0100, 4'b0000, 4'b1111, 16'h0400, 1'b0);
    check("ch2 state cleared const", snd_of(2), 96);
    frame("dropped", 4'b0001, 4'b0000, 4'b1111, 16'h0001, 1'b1);
    for (int k = 0; k < 12; k++) frame("sat_pos", 4'b1111, 4'b0000, 4'b1111, 16'h7777, 1'b0);
    check("sat ch_snd0 const", snd_of(0), 8160);
    check("sat mix const", int'(bus.mix), 32640);
    check("sat mix14 const", int'(bus14.mix), 8191);
    for (int k = 0; k < 12; k++) frame("sat_neg", 4'b1111, 4'b0000, 4'b1111, 16'hFFFF, 1'b0);
    check("neg sat mix const", int'(bus.mix), -32768);
    for (int k = 0; k < 8; k++)
      frame("random", 4'($urandom), 4'b0000, 4'($urandom_range(15, 4)), 16'($urandom), 1'b0);
`ifdef JT7759_MCH_GAIN_EN
    frame("gain_clr", 4'b0000, 4'b1111, 4'b1111, 16'h0000, 1'b0);
    bus.gain[3:0] = 4'd4;
    m_gain[0] = 4;
    frame("gain", 4'b0001, 4'b0000, 4'b1111, 16'h0004, 1'b0);
    check("gain mix const", int'(bus.mix), 48);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
